// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga core: data-memory request/response bundles.
// Imported by the MEM-stage memory models.
package tartaruga_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } dmem_rsp_t;

endpackage

// File: rtl/dmem_rsp_fifo.sv
// In-order response queue; each entry waits out its own countdown before
// it may be presented at the head.
module dmem_rsp_fifo
    import tartaruga_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 2,
    localparam int unsigned PW     = $clog2(DEPTH)
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      push_i,
    input  dmem_rsp_t push_data_i,
    input  logic      pop_i,
    output logic      head_ready_o,
    output dmem_rsp_t head_data_o,
    output logic [PW:0] count_o
);

    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CD_INIT = CW'(LATENCY - 1);

    dmem_rsp_t         data_q [DEPTH];
    logic [CW-1:0]     cd_q   [DEPTH];
    logic [CW-1:0]     cd_d   [DEPTH];
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic              push, pop;

    assign push = push_i & (cnt_q != (PW+1)'(DEPTH));
    assign pop  = pop_i & head_ready_o;

    assign head_ready_o = (cnt_q != '0) & (cd_q[rd_q] == '0);
    assign head_data_o  = data_q[rd_q];
    assign count_o      = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            cd_d[i] = (cd_q[i] != '0) ? cd_q[i] - 1'b1 : '0;
        end
        if (push) begin
            cd_d[wr_q] = CD_INIT;
            wr_d       = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                cd_q[i] <= cd_d[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_q[wr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the MEM stage: array access at request accept,
// in-order responses delayed by LATENCY cycles.
module dmem_responder
    import tartaruga_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_error_o
);

    localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned PW = $clog2(MAX_OUTSTANDING);

    dmem_req_t     req;
    dmem_rsp_t     push_rsp, head_rsp;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [IW-1:0] idx;
    logic [4:0]    sh;
    logic [31:0]   word, lane, rdata, wd_sh;
    logic [3:0]    be;
    logic          misalign, bad_size, oor, err, accept, head_ready;
    logic [PW:0]   count;

    assign req = '{addr: req_addr_i, we: req_we_i, size: req_size_i,
                   is_unsigned: req_unsigned_i, wdata: req_wdata_i};

    assign idx   = req.addr[IW+1:2];
    assign sh    = {req.addr[1:0], 3'b000};
    assign word  = mem_q[idx];
    assign lane  = word >> sh;
    assign wd_sh = req.wdata << sh;
    assign oor   = req.addr[31:2] >= 30'(DEPTH_WORDS);
    assign err   = misalign | bad_size | oor;

    // Store lanes and load extension; errors suppress both write and data.
    always_comb begin
        misalign = 1'b0;
        bad_size = 1'b0;
        be       = '0;
        rdata    = '0;
        unique case (req.size)
            MEM_BYTE: begin
                be    = 4'b0001 << req.addr[1:0];
                rdata = req.is_unsigned ? {24'b0, lane[7:0]}
                                        : {{24{lane[7]}}, lane[7:0]};
            end
            MEM_HALF: begin
                misalign = req.addr[0];
                be       = 4'b0011 << req.addr[1:0];
                rdata    = req.is_unsigned ? {16'b0, lane[15:0]}
                                           : {{16{lane[15]}}, lane[15:0]};
            end
            MEM_WORD: begin
                misalign = req.addr[1:0] != 2'b00;
                be       = 4'b1111;
                rdata    = word;
            end
            default: bad_size = 1'b1;
        endcase
        if (err || req.we) rdata = '0;
        if (err || !req.we) be = '0;
    end

    assign req_ready_o = rstn_i & (count < (PW+1)'(MAX_OUTSTANDING));
    assign accept      = req_valid_i & req_ready_o;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wd_sh[8*b +: 8];
            end
        end
    end

    assign push_rsp = '{rdata: rdata, error: err};

    dmem_rsp_fifo #(
        .DEPTH   (MAX_OUTSTANDING),
        .LATENCY (LATENCY)
    ) u_fifo (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .push_i       (accept),
        .push_data_i  (push_rsp),
        .pop_i        (rsp_valid_o & rsp_ready_i),
        .head_ready_o (head_ready),
        .head_data_o  (head_rsp),
        .count_o      (count)
    );

    assign rsp_valid_o = head_ready;
    assign rsp_rdata_o = head_ready ? head_rsp.rdata : '0;
    assign rsp_error_o = head_ready & head_rsp.error;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, 4 outstanding, 1024 words).
module tb_dmem_responder;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;

    int nerr = 0;
    int nchk = 0;
    int lat;

    dmem_responder #(
        .DEPTH_WORDS     (1024),
        .LATENCY         (2),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_error_o    (rsp_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] wd);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = a;
        req_wdata_i    = wd;
    endtask

    task automatic get_rsp(input string tag, input logic [31:0] ed,
                           input logic ee);
        int n = 0;
        while (!rsp_valid_o && n < 16) begin
            @(negedge clk_i);
            n++;
        end
        chk({tag, "_v"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, "_d"}, rsp_rdata_o, ed);
        chk({tag, "_e"}, 32'(rsp_error_o), 32'(ee));
        @(posedge clk_i);
        #1;
    endtask

    task automatic xfer(input string tag, input logic we,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee,
                        output int l);
        @(negedge clk_i);
        drive(we, sz, uns, a, wd);
        chk({tag, "_rdy"}, 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        l = 0;
        while (!rsp_valid_o && l < 16) begin
            @(negedge clk_i);
            l++;
        end
        chk({tag, "_v"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, "_d"}, rsp_rdata_o, ed);
        chk({tag, "_e"}, 32'(rsp_error_o), 32'(ee));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rstn_i = 1'b0;
        rsp_ready_i = 1'b1;
        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        req_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_rdy", 32'(req_ready_o), 32'd0);
        chk("rst_v", 32'(rsp_valid_o), 32'd0);
        chk("rst_d", rsp_rdata_o, 32'd0);
        chk("rst_e", 32'(rsp_error_o), 32'd0);
        rstn_i = 1'b1;

        xfer("st_w", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, lat);
        xfer("ld_w", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, lat);
        chk("ld_lat", 32'(lat), 32'd2);

        xfer("st_b", 1, 2'b00, 0, 32'h12, 32'h55, 32'h0, 0, lat);
        xfer("ld_w2", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDE55BEEF, 0, lat);
        xfer("ld_bu", 0, 2'b00, 1, 32'h13, 32'h0, 32'h000000DE, 0, lat);
        xfer("ld_bs", 0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFFBE, 0, lat);

        xfer("st_h", 1, 2'b01, 0, 32'h20, 32'h8001, 32'h0, 0, lat);
        xfer("ld_hs", 0, 2'b01, 0, 32'h20, 32'h0, 32'hFFFF8001, 0, lat);
        xfer("ld_hu", 0, 2'b01, 1, 32'h20, 32'h0, 32'h00008001, 0, lat);

        xfer("e_mis_w", 0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1, lat);
        xfer("e_mis_h", 1, 2'b01, 0, 32'h21, 32'hFFFF, 32'h0, 1, lat);
        xfer("e_oor", 0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1, lat);
        xfer("e_size", 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, lat);
        xfer("e_keep", 0, 2'b01, 1, 32'h20, 32'h0, 32'h00008001, 0, lat);

        for (int i = 0; i < 5; i++) begin
            xfer("bp_st", 1, 2'b10, 0, 32'h40 + 32'(4*i),
                 32'hC0DE0000 | 32'(i), 32'h0, 0, lat);
        end

        rsp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("bp_rdy", 32'(req_ready_o), 32'd1);
            drive(1'b0, 2'b10, 1'b0, 32'h40 + 32'(4*i), 32'h0);
        end
        @(negedge clk_i);
        drive(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
        chk("bp_full", 32'(req_ready_o), 32'd0);
        chk("bp_v0", 32'(rsp_valid_o), 32'd1);
        chk("bp_d0", rsp_rdata_o, 32'hC0DE0000);
        @(negedge clk_i);
        chk("bp_hold_rdy", 32'(req_ready_o), 32'd0);
        chk("bp_hold_d", rsp_rdata_o, 32'hC0DE0000);
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("bp_pop_rdy", 32'(req_ready_o), 32'd1);
        chk("bp_d1", rsp_rdata_o, 32'hC0DE0001);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        get_rsp("bp_r2", 32'hC0DE0002, 1'b0);
        get_rsp("bp_r3", 32'hC0DE0003, 1'b0);
        get_rsp("bp_r4", 32'hC0DE0004, 1'b0);
        repeat (4) @(negedge clk_i);
        chk("bp_empty", 32'(rsp_valid_o), 32'd0);

        rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            drive(1'b0, 2'b10, 1'b0, 32'h40 + 32'(4*i), 32'h0);
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk("rs_pend", 32'(rsp_valid_o), 32'd1);
        rstn_i = 1'b0;
        #1;
        chk("rs_rdy", 32'(req_ready_o), 32'd0);
        chk("rs_v", 32'(rsp_valid_o), 32'd0);
        chk("rs_d", rsp_rdata_o, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        rsp_ready_i = 1'b1;
        #1;
        chk("rs_rdy_rel", 32'(req_ready_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("rs_stale", 32'(rsp_valid_o), 32'd0);
        end
        xfer("rs_ld1", 0, 2'b10, 0, 32'h44, 32'h0, 32'hC0DE0001, 0, lat);
        xfer("rs_ld2", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDE55BEEF, 0, lat);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
